skew_feeder: RTL and testbench

Downstream consumer of the pixel/slice counter in the systolic-array datapath. Turns the counter's (slice, pixel) position into linear read addresses for the input tile buffer, captures the returned row-vector, and drives it into the array's ROWS input lanes with diagonal skew: lane r delayed r cycles. Owns the counter's `enable_row_count`, so one `start` sequences exactly one WIDTH×HEIGHT frame.

---
 rtl/skew_feeder_pkg.sv | 27 ++
 rtl/skew_delay_line.sv | 34 +++
 rtl/skew_feeder.sv | 112 +++++++++++
 tb/tb_skew_feeder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/skew_feeder_pkg.sv
// rtl/skew_feeder_pkg.sv - shared types and width helpers for the skewed row feeder
package skew_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int STATE_W = 3;

  // Counter ports keep at least one bit even for single-entry dimensions.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int addr_width(input int width, input int height);
    return clog2_min1(width * height);
  endfunction

  function automatic int lane_width(input int rows, input int data_w);
    return rows * data_w;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage data+valid shift register, data forced to 0 when invalid
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - frame sequencer and skewed lane driver; SKEW_FEEDER_SKEW_EN selects diagonal skew
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int ROWS   = 4,
  parameter int DATA_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [clog2_min1(WIDTH)-1:0]       pixel_cntr,
  input  logic [clog2_min1(HEIGHT)-1:0]      slice_cntr,
  output logic                               enable_row_count,
  output logic                               rd_en,
  output logic [addr_width(WIDTH,HEIGHT)-1:0] rd_addr,
  input  logic [lane_width(ROWS,DATA_W)-1:0] rd_data,
  output logic [lane_width(ROWS,DATA_W)-1:0] lane_data,
  output logic [ROWS-1:0]                    lane_valid,
  output logic                               busy,
  output logic                               done
);

  localparam int PIX_W  = clog2_min1(WIDTH);
  localparam int SLC_W  = clog2_min1(HEIGHT);
  localparam int ADDR_W = addr_width(WIDTH, HEIGHT);

`ifdef SKEW_FEEDER_SKEW_EN
  localparam bit SKEW      = 1'b1;
  localparam int DRAIN_LEN = ROWS;
`else
  localparam bit SKEW      = 1'b0;
  localparam int DRAIN_LEN = 1;
`endif
  localparam int DRAIN_W = clog2_min1(DRAIN_LEN);

  state_t             state, state_nx;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nx;
  logic               rd_valid;
  logic [ADDR_W-1:0]  addr_calc;
  logic               last_pixel, last_slice;

  assign last_pixel = (pixel_cntr == PIX_W'(WIDTH - 1));
  assign last_slice = (slice_cntr == SLC_W'(HEIGHT - 1));
  assign addr_calc  = ADDR_W'(slice_cntr) * ADDR_W'(WIDTH) + ADDR_W'(pixel_cntr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      rd_valid  <= rd_en;
    end
  end

  always_comb begin
    state_nx         = state;
    drain_cnt_nx     = drain_cnt;
    rd_en            = 1'b0;
    enable_row_count = 1'b0;
    rd_addr          = '0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_ALIGN;
      end
      // Enter RUN only once the free-running pixel counter is about to wrap.
      S_ALIGN: begin
        if (last_pixel) state_nx = S_RUN;
      end
      S_RUN: begin
        rd_en            = 1'b1;
        enable_row_count = 1'b1;
        rd_addr          = addr_calc;
        if (last_pixel && last_slice) begin
          state_nx     = S_DRAIN;
          drain_cnt_nx = DRAIN_W'(DRAIN_LEN - 1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_nx = S_DONE;
        else drain_cnt_nx = drain_cnt - 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH (SKEW ? r + 1 : 1),
      .DATA_W(DATA_W)
    ) u_delay (
      .clk      (clk),
      .rst      (rst),
      .in_data  (rd_data[r*DATA_W +: DATA_W]),
      .in_valid (rd_valid),
      .out_data (lane_data[r*DATA_W +: DATA_W]),
      .out_valid(lane_valid[r])
    );
  end

endmodule

// File: tb/tb_skew_feeder.sv
// tb/tb_skew_feeder.sv - randomized frame checks of skew_feeder against a timing/data reference model
module tb_skew_feeder;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ROWS   = 3;
  localparam int DATA_W = 8;
  localparam int N      = WIDTH * HEIGHT;
  localparam int LW     = ROWS * DATA_W;
`ifdef SKEW_FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int DRAIN = SKEW ? ROWS : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    pixel_cntr;
  logic [0:0]    slice_cntr;
  logic          enable_row_count;
  logic          rd_en;
  logic [2:0]    rd_addr;
  logic [LW-1:0] rd_data;
  logic [LW-1:0] lane_data;
  logic [ROWS-1:0] lane_valid;
  logic          busy;
  logic          done;

  logic [LW-1:0] mem [N];
  int total = 0;
  int bad   = 0;

  skew_feeder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_cntr(pixel_cntr), .slice_cntr(slice_cntr),
    .enable_row_count(enable_row_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .lane_data(lane_data), .lane_valid(lane_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pixel/slice counter the feeder is paired with.
  always @(posedge clk) begin
    if (rst) begin
      pixel_cntr <= '0;
      slice_cntr <= '0;
    end else begin
      pixel_cntr <= 2'((int'(pixel_cntr) + 1) % WIDTH);
      if (int'(pixel_cntr) == WIDTH - 1 && enable_row_count)
        slice_cntr <= 1'((int'(slice_cntr) + 1) % HEIGHT);
    end
  end

  // Tile buffer: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= LW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_enable_row_count"}, 32'(enable_row_count), 32'(0));
    chk({tag, "_rd_en"}, 32'(rd_en), 32'(0));
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(0));
    chk({tag, "_lane_data"}, 32'(lane_data), 32'(0));
    chk({tag, "_lane_valid"}, 32'(lane_valid), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  task automatic run_frame(input bit start_in_run, input bit start_in_done);
    int p, t0, exp_done, lat, k;
    bit in_run, v;
    logic [LW-1:0] word;
    logic [DATA_W-1:0] exp_lane;
    foreach (mem[a]) mem[a] = LW'($urandom);
    @(posedge clk); #1;
    p = int'(pixel_cntr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Cycle 0 is the first cycle after start; ALIGN runs until the pixel counter hits WIDTH-1.
    t0       = (WIDTH - 1) - ((p + 1) % WIDTH) + 1;
    exp_done = t0 + N - 1 + DRAIN + 1;
    for (int c = 0; c <= exp_done + 1; c++) begin
      @(negedge clk);
      in_run = (c >= t0) && (c < t0 + N);
      chk("busy", 32'(busy), 32'(c <= exp_done));
      chk("done", 32'(done), 32'(c == exp_done));
      chk("rd_en", 32'(rd_en), 32'(in_run));
      chk("enable_row_count", 32'(enable_row_count), 32'(in_run));
      chk("rd_addr", 32'(rd_addr), in_run ? 32'(c - t0) : 32'(0));
      for (int r = 0; r < ROWS; r++) begin
        lat = 2 + (SKEW ? r : 0);
        k   = c - t0 - lat;
        v   = (k >= 0) && (k < N);
        word = v ? mem[k] : '0;
        exp_lane = DATA_W'(word >> (r * DATA_W));
        chk($sformatf("lane_valid[%0d]", r), 32'(lane_valid[r]), 32'(v));
        chk($sformatf("lane_data[%0d]", r), 32'(lane_data[r*DATA_W +: DATA_W]), 32'(exp_lane));
      end
      if (start_in_run && c == t0 + 2) start = 1'b1;
      else if (start_in_done && c == exp_done) start = 1'b1;
      else start = 1'b0;
    end
    chk("slice_wrap", 32'(slice_cntr), 32'(0));
  endtask

  task automatic reset_mid_run();
    bit found = 1'b0;
    foreach (mem[a]) mem[a] = LW'($urandom);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 3'd5) found = 1'b1;
    end
    chk("reach_addr5", 32'(found), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    chk("mid_reset_pixel", 32'(pixel_cntr), 32'(0));
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    repeat ($urandom_range(0, 3)) @(posedge clk);
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b1);
    run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b0);
    reset_mid_run();
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
